// File: rtl/lsq_mem_scheduler.sv
// lsq_mem_scheduler
//
// Sequences load/store operations issued by the LSQ onto a single-port,
// fixed-latency data memory. It keeps one memory access in flight and
// returns completions on a single writeback port. Issued ops are held in an
// in-order FIFO. Byte loads are sign-extended. Loads already satisfied by LSQ
// forwarding are merged onto the same writeback port.
//
// Optional feature: define LSQ_MEM_BYPASS_EN to route forwarded loads
// (in_from_lsq=1) around the FIFO. They go through a 1-entry bypass register
// and complete out of order. When the macro is undefined, forwarded loads
// queue in order and complete via IDLE -> DONE.
//
// Parameters
//   QDEPTH   request FIFO entries (power of two, >= 2)
//   MEM_LAT  cycles from mem_req to valid mem_rdata (>= 1)
//
// Ports
//   clk, rst        clock; asynchronous active-high reset
//   flush           synchronous drop of queued and in-flight ops
//   in_*            LSQ issue handshake (in_valid/in_ready) and op fields
//   mem_*           registered memory request strobe/fields; mem_rdata returns
//                   MEM_LAT cycles after mem_req
//   wb_*            registered one-cycle completion strobe and fields
module lsq_mem_scheduler #(
    parameter int QDEPTH  = 4,
    parameter int MEM_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic [5:0]  in_rob,
    input  logic [5:0]  in_dest,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_sw_data,
    input  logic        in_load_store,
    input  logic        in_size,
    input  logic        in_from_lsq,
    input  logic [31:0] in_lw_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_byte,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic [31:0] wb_pc,
    output logic [31:0] wb_data,
    output logic [5:0]  wb_rob,
    output logic [5:0]  wb_dest,
    output logic        wb_is_store
);

    localparam int AW   = $clog2(QDEPTH);
    localparam int CNTW = AW + 1;
    localparam int CW   = $clog2(MEM_LAT + 1);
    localparam logic [CW-1:0] LAT_M1 = CW'(MEM_LAT - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    function automatic logic [31:0] load_ext(input logic [31:0] d, input logic byte_op);
        return byte_op ? {{24{d[7]}}, d[7:0]} : d;
    endfunction

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   rd_ptr_q, wr_ptr_q;
    logic [CNTW-1:0] count_q;

    logic [31:0] q_pc   [QDEPTH];
    logic [31:0] q_addr [QDEPTH];
    logic [31:0] q_sw   [QDEPTH];
    logic [31:0] q_lw   [QDEPTH];
    logic [5:0]  q_rob  [QDEPTH];
    logic [5:0]  q_dest [QDEPTH];
    logic        q_ls   [QDEPTH];
    logic        q_size [QDEPTH];
    logic        q_fl   [QDEPTH];

    logic        mem_req_q, mem_we_q, mem_byte_q;
    logic        mem_req_d, mem_we_d, mem_byte_d;
    logic [31:0] mem_addr_q, mem_wdata_q, mem_addr_d, mem_wdata_d;

    logic        wb_valid_q, wb_st_q, wb_valid_d, wb_st_d;
    logic [31:0] wb_pc_q, wb_data_q, wb_pc_d, wb_data_d;
    logic [5:0]  wb_rob_q, wb_dest_q, wb_rob_d, wb_dest_d;

    logic        fsm_done;
    logic [31:0] fsm_data;
    logic        fifo_full, fifo_empty, push, pop;

    assign fifo_full  = (count_q == CNTW'(QDEPTH));
    assign fifo_empty = (count_q == '0);

    // Head-of-queue view; the head stays put until DONE exits.
    logic [31:0] h_pc, h_addr, h_sw, h_lw;
    logic [5:0]  h_rob, h_dest;
    logic        h_ls, h_size, h_fl;
    assign h_pc   = q_pc[rd_ptr_q];
    assign h_addr = q_addr[rd_ptr_q];
    assign h_sw   = q_sw[rd_ptr_q];
    assign h_lw   = q_lw[rd_ptr_q];
    assign h_rob  = q_rob[rd_ptr_q];
    assign h_dest = q_dest[rd_ptr_q];
    assign h_ls   = q_ls[rd_ptr_q];
    assign h_size = q_size[rd_ptr_q];
    assign h_fl   = q_fl[rd_ptr_q];

`ifdef LSQ_MEM_BYPASS_EN
    logic        byp_vld_q, byp_vld_d, byp_acc;
    logic [31:0] byp_pc_q, byp_data_q, byp_pc_d, byp_data_d;
    logic [5:0]  byp_rob_q, byp_dest_q, byp_rob_d, byp_dest_d;

    // Forwarded loads are gated by the bypass slot, everything else by the FIFO.
    assign in_ready = !rst && (in_from_lsq ? !byp_vld_q : !fifo_full);
    assign byp_acc  = in_valid && in_ready && in_from_lsq && !flush;
    assign push     = in_valid && in_ready && !in_from_lsq && !flush;
`else
    assign in_ready = !rst && !fifo_full;
    assign push     = in_valid && in_ready && !flush;
`endif
    assign pop = (state_q == S_DONE) && !flush;

    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[wr_ptr_q]   <= in_pc;
            q_addr[wr_ptr_q] <= in_addr;
            q_sw[wr_ptr_q]   <= in_sw_data;
            q_lw[wr_ptr_q]   <= in_lw_data;
            q_rob[wr_ptr_q]  <= in_rob;
            q_dest[wr_ptr_q] <= in_dest;
            q_ls[wr_ptr_q]   <= in_load_store;
            q_size[wr_ptr_q] <= in_size;
            q_fl[wr_ptr_q]   <= in_from_lsq;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CNTW'(push) - CNTW'(pop);
        end
    end

    // Next-state logic. The memory outputs are registered from the transition
    // into ISSUE, so mem_req is high exactly while the FSM sits in ISSUE.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_req_d   = 1'b0;
        mem_we_d    = 1'b0;
        mem_byte_d  = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        fsm_done    = 1'b0;
        fsm_data    = '0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    if (h_fl) begin
                        state_d  = S_DONE;
                        fsm_done = 1'b1;
                        fsm_data = h_lw;
                    end else begin
                        state_d     = S_ISSUE;
                        mem_req_d   = 1'b1;
                        mem_we_d    = h_ls;
                        mem_byte_d  = h_size;
                        mem_addr_d  = h_addr;
                        mem_wdata_d = h_sw;
                    end
                end
            end
            S_ISSUE: begin
                if (h_ls) begin
                    state_d  = S_DONE;
                    fsm_done = 1'b1;
                end else begin
                    state_d = S_WAIT;
                    cnt_d   = LAT_M1;
                end
            end
            S_WAIT: begin
                // Counter reaches 0 in the cycle mem_rdata is valid.
                if (cnt_q == '0) begin
                    state_d  = S_DONE;
                    fsm_done = 1'b1;
                    fsm_data = load_ext(mem_rdata, h_size);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (flush) begin
            state_d     = S_IDLE;
            cnt_d       = '0;
            mem_req_d   = 1'b0;
            mem_we_d    = 1'b0;
            mem_byte_d  = 1'b0;
            mem_addr_d  = '0;
            mem_wdata_d = '0;
            fsm_done    = 1'b0;
            fsm_data    = '0;
        end
    end

    // Writeback arbitration: the FSM completion always wins the port.
    always_comb begin
        wb_valid_d = 1'b0;
        wb_pc_d    = '0;
        wb_data_d  = '0;
        wb_rob_d   = '0;
        wb_dest_d  = '0;
        wb_st_d    = 1'b0;
        if (fsm_done) begin
            wb_valid_d = 1'b1;
            wb_pc_d    = h_pc;
            wb_data_d  = fsm_data;
            wb_rob_d   = h_rob;
            wb_dest_d  = h_dest;
            wb_st_d    = h_ls;
        end
`ifdef LSQ_MEM_BYPASS_EN
        byp_vld_d  = byp_vld_q;
        byp_pc_d   = byp_pc_q;
        byp_data_d = byp_data_q;
        byp_rob_d  = byp_rob_q;
        byp_dest_d = byp_dest_q;
        if (flush) begin
            byp_vld_d = 1'b0;
        end else if (!fsm_done) begin
            if (byp_vld_q) begin
                wb_valid_d = 1'b1;
                wb_pc_d    = byp_pc_q;
                wb_data_d  = byp_data_q;
                wb_rob_d   = byp_rob_q;
                wb_dest_d  = byp_dest_q;
                byp_vld_d  = 1'b0;
            end else if (byp_acc) begin
                // Port is free: complete the forwarded load without parking it.
                wb_valid_d = 1'b1;
                wb_pc_d    = in_pc;
                wb_data_d  = in_lw_data;
                wb_rob_d   = in_rob;
                wb_dest_d  = in_dest;
            end
        end else if (byp_acc) begin
            byp_vld_d  = 1'b1;
            byp_pc_d   = in_pc;
            byp_data_d = in_lw_data;
            byp_rob_d  = in_rob;
            byp_dest_d = in_dest;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_byte_q  <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            wb_valid_q  <= 1'b0;
            wb_pc_q     <= '0;
            wb_data_q   <= '0;
            wb_rob_q    <= '0;
            wb_dest_q   <= '0;
            wb_st_q     <= 1'b0;
`ifdef LSQ_MEM_BYPASS_EN
            byp_vld_q   <= 1'b0;
            byp_pc_q    <= '0;
            byp_data_q  <= '0;
            byp_rob_q   <= '0;
            byp_dest_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_byte_q  <= mem_byte_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            wb_valid_q  <= wb_valid_d;
            wb_pc_q     <= wb_pc_d;
            wb_data_q   <= wb_data_d;
            wb_rob_q    <= wb_rob_d;
            wb_dest_q   <= wb_dest_d;
            wb_st_q     <= wb_st_d;
`ifdef LSQ_MEM_BYPASS_EN
            byp_vld_q   <= byp_vld_d;
            byp_pc_q    <= byp_pc_d;
            byp_data_q  <= byp_data_d;
            byp_rob_q   <= byp_rob_d;
            byp_dest_q  <= byp_dest_d;
`endif
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_byte    = mem_byte_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign wb_valid    = wb_valid_q;
    assign wb_pc       = wb_pc_q;
    assign wb_data     = wb_data_q;
    assign wb_rob      = wb_rob_q;
    assign wb_dest     = wb_dest_q;
    assign wb_is_store = wb_st_q;

endmodule

// File: tb/tb_lsq_mem_scheduler.sv
module tb_lsq_mem_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_pc = '0;
    logic [5:0]  in_rob = '0;
    logic [5:0]  in_dest = '0;
    logic [31:0] in_addr = '0;
    logic [31:0] in_sw_data = '0;
    logic        in_load_store = 1'b0;
    logic        in_size = 1'b0;
    logic        in_from_lsq = 1'b0;
    logic [31:0] in_lw_data = '0;
    logic        mem_req, mem_we, mem_byte;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        wb_valid, wb_is_store;
    logic [31:0] wb_pc, wb_data;
    logic [5:0]  wb_rob, wb_dest;

    int checks = 0;
    int errors = 0;

    lsq_mem_scheduler #(.QDEPTH(4), .MEM_LAT(2)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_rob(in_rob),
        .in_dest(in_dest), .in_addr(in_addr), .in_sw_data(in_sw_data),
        .in_load_store(in_load_store), .in_size(in_size), .in_from_lsq(in_from_lsq),
        .in_lw_data(in_lw_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_byte(mem_byte), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_data(wb_data), .wb_rob(wb_rob),
        .wb_dest(wb_dest), .wb_is_store(wb_is_store)
    );

    always #5 clk = ~clk;

    // Memory model: read data appears two cycles after the mem_req cycle.
    function automatic logic [31:0] memval(input logic [31:0] a);
        if (a == 32'h100) return 32'h12345678;
        if (a == 32'h200) return 32'h000000F0;
        return a ^ 32'hA5A50000;
    endfunction

    logic        p1_v;
    logic [31:0] p1_a;
    always @(posedge clk) begin
        p1_v      <= mem_req && !mem_we;
        p1_a      <= mem_addr;
        mem_rdata <= p1_v ? memval(p1_a) : 32'h0;
    end

    logic [5:0]  robs  [8];
    logic [31:0] datas [8];
    int          ks    [8];
    int          n;

    task automatic push_op(input logic [31:0] pc, input logic [5:0] rob, input logic [5:0] dest,
                           input logic [31:0] addr, input logic [31:0] sw, input logic ls,
                           input logic sz, input logic fl, input logic [31:0] lw);
        in_pc = pc; in_rob = rob; in_dest = dest; in_addr = addr; in_sw_data = sw;
        in_load_store = ls; in_size = sz; in_from_lsq = fl; in_lw_data = lw;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
        checks++; if ({mem_req, mem_we, mem_byte, mem_addr, mem_wdata} !== 67'h0) begin errors++; $display("FAIL reset_mem got %b %h exp 0", mem_req, mem_addr); end
        checks++; if ({wb_valid, wb_is_store, wb_pc, wb_data, wb_rob, wb_dest} !== 78'h0) begin errors++; $display("FAIL reset_wb got %b %h exp 0", wb_valid, wb_data); end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got %b exp 1", in_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_word_load();
        push_op(32'h1000, 6'd5, 6'd7, 32'h100, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            checks++; if (mem_req !== (k == 2)) begin errors++; $display("FAIL word_load_mem_req k=%0d got %b exp %b", k, mem_req, (k == 2)); end
            checks++; if (wb_valid !== (k == 5)) begin errors++; $display("FAIL word_load_wb_valid k=%0d got %b exp %b", k, wb_valid, (k == 5)); end
            if (k == 2) begin
                checks++; if ({mem_we, mem_byte, mem_addr} !== {1'b0, 1'b0, 32'h100}) begin errors++; $display("FAIL word_load_req_fields got we=%b byte=%b addr=%h exp 0 0 00000100", mem_we, mem_byte, mem_addr); end
            end
            if (k == 5) begin
                checks++; if (wb_data !== 32'h12345678) begin errors++; $display("FAIL word_load_data got %h exp 12345678", wb_data); end
                checks++; if ({wb_rob, wb_dest, wb_pc, wb_is_store} !== {6'd5, 6'd7, 32'h1000, 1'b0}) begin errors++; $display("FAIL word_load_fields got rob=%0d dest=%0d pc=%h st=%b exp 5 7 00001000 0", wb_rob, wb_dest, wb_pc, wb_is_store); end
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_byte_load();
        push_op(32'h1004, 6'd6, 6'd8, 32'h200, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 2) begin
                checks++; if ({mem_req, mem_we, mem_byte} !== 3'b101) begin errors++; $display("FAIL byte_load_req got %b%b%b exp 101", mem_req, mem_we, mem_byte); end
            end
            checks++; if (wb_valid !== (k == 5)) begin errors++; $display("FAIL byte_load_wb_valid k=%0d got %b exp %b", k, wb_valid, (k == 5)); end
            if (k == 5) begin
                checks++; if (wb_data !== 32'hFFFFFFF0) begin errors++; $display("FAIL byte_load_sext got %h exp FFFFFFF0", wb_data); end
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_byte_store();
        push_op(32'h1008, 6'd9, 6'd3, 32'h104, 32'hAB, 1'b1, 1'b1, 1'b0, 32'h0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            checks++; if (mem_req !== (k == 2)) begin errors++; $display("FAIL store_mem_req k=%0d got %b exp %b", k, mem_req, (k == 2)); end
            if (k == 2) begin
                checks++; if ({mem_we, mem_byte, mem_addr, mem_wdata} !== {1'b1, 1'b1, 32'h104, 32'hAB}) begin errors++; $display("FAIL store_req_fields got we=%b byte=%b addr=%h wd=%h exp 1 1 00000104 000000ab", mem_we, mem_byte, mem_addr, mem_wdata); end
            end
            checks++; if (wb_valid !== (k == 3)) begin errors++; $display("FAIL store_wb_valid k=%0d got %b exp %b", k, wb_valid, (k == 3)); end
            if (k == 3) begin
                checks++; if ({wb_is_store, wb_data, wb_rob, wb_dest} !== {1'b1, 32'h0, 6'd9, 6'd3}) begin errors++; $display("FAIL store_wb_fields got st=%b data=%h rob=%0d dest=%0d exp 1 0 9 3", wb_is_store, wb_data, wb_rob, wb_dest); end
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_fifo_full();
        for (int r = 1; r <= 4; r++) begin
            if (r == 4) begin
                checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_ready_at3 got %b exp 1", in_ready); end
            end
            push_op(32'h2000 + 32'(4 * r), 6'(r), 6'(r + 20), 32'(16 * r), 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        end
        in_rob = 6'd5; in_addr = 32'h50; in_valid = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_ready_at4 got %b exp 0", in_ready); end
        in_valid = 1'b0;
        n = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (wb_valid) begin
                if (n < 8) begin robs[n] = wb_rob; datas[n] = wb_data; end
                n++;
            end
        end
        checks++; if (n !== 4) begin errors++; $display("FAIL full_completions got %0d exp 4", n); end
        for (int r = 1; r <= 4 && r <= n; r++) begin
            checks++; if (robs[r-1] !== 6'(r)) begin errors++; $display("FAIL full_order idx=%0d got rob %0d exp %0d", r - 1, robs[r-1], r); end
            checks++; if (datas[r-1] !== (32'(16 * r) ^ 32'hA5A50000)) begin errors++; $display("FAIL full_data idx=%0d got %h exp %h", r - 1, datas[r-1], 32'(16 * r) ^ 32'hA5A50000); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_forward();
        push_op(32'h3000, 6'd10, 6'd12, 32'h300, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        push_op(32'h3004, 6'd11, 6'd13, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF);
        n = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (wb_valid) begin
                if (n < 8) begin robs[n] = wb_rob; datas[n] = wb_data; ks[n] = k; end
                n++;
            end
        end
        checks++; if (n !== 2) begin errors++; $display("FAIL fwd_completions got %0d exp 2", n); end
        if (n >= 2) begin
`ifdef LSQ_MEM_BYPASS_EN
            checks++; if ({robs[0], datas[0]} !== {6'd11, 32'hDEADBEEF}) begin errors++; $display("FAIL fwd_first got rob=%0d data=%h exp 11 deadbeef", robs[0], datas[0]); end
            checks++; if (ks[0] !== 1) begin errors++; $display("FAIL fwd_bypass_latency got %0d exp 1", ks[0]); end
            checks++; if ({robs[1], datas[1]} !== {6'd10, 32'h300 ^ 32'hA5A50000}) begin errors++; $display("FAIL fwd_second got rob=%0d data=%h exp 10 %h", robs[1], datas[1], 32'h300 ^ 32'hA5A50000); end
`else
            checks++; if ({robs[0], datas[0]} !== {6'd10, 32'h300 ^ 32'hA5A50000}) begin errors++; $display("FAIL fwd_first got rob=%0d data=%h exp 10 %h", robs[0], datas[0], 32'h300 ^ 32'hA5A50000); end
            checks++; if ({robs[1], datas[1]} !== {6'd11, 32'hDEADBEEF}) begin errors++; $display("FAIL fwd_second got rob=%0d data=%h exp 11 deadbeef", robs[1], datas[1]); end
`endif
        end
        @(posedge clk); #1;
    endtask

    task automatic test_flush();
        push_op(32'h4000, 6'd20, 6'd1, 32'h400, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        repeat (3) @(negedge clk);
        // In WAIT now; an op offered alongside the flush must be dropped.
        flush = 1'b1;
        in_rob = 6'd22; in_addr = 32'h480; in_load_store = 1'b0; in_from_lsq = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            checks++; if ({wb_valid, mem_req} !== 2'b00) begin errors++; $display("FAIL flush_quiet k=%0d got wb=%b req=%b exp 0 0", k, wb_valid, mem_req); end
        end
        @(posedge clk); #1;
        push_op(32'h4004, 6'd21, 6'd2, 32'h404, 32'h55, 1'b1, 1'b0, 1'b0, 32'h0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            checks++; if (mem_req !== (k == 2)) begin errors++; $display("FAIL flush_next_req k=%0d got %b exp %b", k, mem_req, (k == 2)); end
            if (k == 2) begin
                checks++; if (mem_addr !== 32'h404) begin errors++; $display("FAIL flush_next_addr got %h exp 00000404", mem_addr); end
            end
            if (k == 3) begin
                checks++; if ({wb_valid, wb_rob, wb_is_store} !== {1'b1, 6'd21, 1'b1}) begin errors++; $display("FAIL flush_next_wb got v=%b rob=%0d st=%b exp 1 21 1", wb_valid, wb_rob, wb_is_store); end
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_wait();
        push_op(32'h5000, 6'd30, 6'd4, 32'h500, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if ({in_ready, mem_req, wb_valid, mem_addr, wb_data} !== 67'h0) begin errors++; $display("FAIL rst_async got rdy=%b req=%b wb=%b addr=%h exp all 0", in_ready, mem_req, wb_valid, mem_addr); end
        @(posedge clk); #1 rst = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL rst_stale_wb k=%0d got %b exp 0", k, wb_valid); end
        end
        @(posedge clk); #1;
        push_op(32'h5004, 6'd31, 6'd5, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h01020304);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
`ifdef LSQ_MEM_BYPASS_EN
            checks++; if (wb_valid !== (k == 1)) begin errors++; $display("FAIL fwd_latency k=%0d got %b exp %b", k, wb_valid, (k == 1)); end
`else
            checks++; if (wb_valid !== (k == 2)) begin errors++; $display("FAIL fwd_latency k=%0d got %b exp %b", k, wb_valid, (k == 2)); end
`endif
            if (wb_valid) begin
                checks++; if ({wb_rob, wb_data, wb_is_store} !== {6'd31, 32'h01020304, 1'b0}) begin errors++; $display("FAIL fwd_data got rob=%0d data=%h exp 31 01020304", wb_rob, wb_data); end
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_word_load();
        test_byte_load();
        test_byte_store();
        test_fifo_full();
        test_forward();
        test_flush();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
